io_console_tx: RTL

Buffered console output port on the Z80 I/O bus. The block decodes CPU `OUT` writes to a data port, queues the bytes in a FIFO, and drains them over an 8N1 serial transmit line. It exposes a status port the CPU polls with `IN`. It also presents the last written character on `charout` for on-board display logic. It sits beside the CPU and memory in the system top level, directly downstream of the CPU I/O write cycle.

---
 rtl/io_console_tx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/io_console_tx.sv
// Console output port on the Z80 I/O bus: OUT writes are queued in a FIFO and
// drained over an 8N1 serial line; a status port reports FIFO/TX/overflow state.
module io_console_tx #(
    parameter logic [7:0] DATA_ADDR    = 8'hBB,
    parameter logic [7:0] STAT_ADDR    = 8'hBC,
    parameter int         DEPTH_LOG2   = 4,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       tx,
    output logic [7:0] charout,
    output logic       fifo_empty,
    output logic       fifo_full
);
    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam int                    BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                  wr_req, stat_rd, data_rd;
    logic                  push, pop, accept, ovf_set, ovf_clr;
    logic                  wr_req_q, stat_rd_q, overflow_q;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [7:0]            charout_q;
    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;

    assign wr_req  = !iorq_n && !wr_n && (addr == DATA_ADDR);
    assign stat_rd = !iorq_n && !rd_n && (addr == STAT_ADDR);
    assign data_rd = !iorq_n && !rd_n && (addr == DATA_ADDR);

    // One push per I/O write cycle, however long the strobe is held.
    assign push       = wr_req && !wr_req_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign accept     = push && (!fifo_full || pop);
    assign ovf_set    = push && fifo_full && !pop;
    assign ovf_clr    = stat_rd_q && !stat_rd;

    always_comb begin
        dout = 8'h00;
        if (stat_rd)
            dout = {4'b0, overflow_q, state_q != IDLE, fifo_full, fifo_empty};
        else if (data_rd)
            dout = charout_q;
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wptr_q] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_req_q   <= 1'b0;
            stat_rd_q  <= 1'b0;
            overflow_q <= 1'b0;
            charout_q  <= 8'h00;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            wr_req_q  <= wr_req;
            stat_rd_q <= stat_rd;
            if (push) charout_q <= din;
            // A fresh overflow beats the read-release clear.
            if (ovf_set)      overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
            if (accept) wptr_q <= wptr_q + 1'b1;
            if (pop)    rptr_q <= rptr_q + 1'b1;
            if (accept && !pop)      count_q <= count_q + 1'b1;
            else if (!accept && pop) count_q <= count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = START;
                    shift_d = mem_q[rptr_q];
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_q == BAUD_LAST) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign charout = charout_q;
endmodule
